// File: rtl/ovr_i_supervisor_if.sv
// rtl/ovr_i_supervisor_if.sv - control/status bundle between the enable request, comparators and the supervisor
interface ovr_i_supervisor_if #(
  parameter int MAX_RETRY = 2
) ();
  logic                           PWM_sync;
  logic                           OVR_I_lft;
  logic                           OVR_I_rght;
  logic                           en_req;
  logic                           clr_fault;
  logic                           drv_en;
  logic                           OVR_I_shtdwn;
  logic                           fault_latched;
  logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt;

  modport master (
    output PWM_sync, OVR_I_lft, OVR_I_rght, en_req, clr_fault,
    input  drv_en, OVR_I_shtdwn, fault_latched, retry_cnt
  );

  modport slave (
    input  PWM_sync, OVR_I_lft, OVR_I_rght, en_req, clr_fault,
    output drv_en, OVR_I_shtdwn, fault_latched, retry_cnt
  );
endinterface

// File: rtl/ovr_i_supervisor.sv
// rtl/ovr_i_supervisor.sv - over-current qualifier and enable sequencer; OVR_I_RETRY_EN adds cool-down/retry
module ovr_i_supervisor #(
  parameter int BLANK_CYC     = 32,
  parameter int FAULT_LIMIT   = 4,
  parameter int RETRY_PERIODS = 8,
  parameter int MAX_RETRY     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ovr_i_supervisor_if.slave bus
);

  localparam int BW = $clog2(BLANK_CYC + 1);
  localparam int FW = $clog2(FAULT_LIMIT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYC);
  localparam logic [FW-1:0] FLT_MAX   = FW'(FAULT_LIMIT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_LATCHED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] blank_q, blank_d, blank_inc;
  logic [FW-1:0] flt_q, flt_d, flt_inc;
  logic          prd_q, prd_d;
  logic          drv_q, sht_q, lat_q;
  logic          qual, shut;

`ifdef OVR_I_RETRY_EN
  localparam int CW = $clog2(RETRY_PERIODS + 1);
  localparam logic [CW-1:0] COOL_MAX  = CW'(RETRY_PERIODS);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [1:0]    ST_COOL   = 2'd3;

  logic [CW-1:0] cool_q, cool_d, cool_inc;
  logic [RW-1:0] retry_q, retry_d, retry_inc;

  assign cool_inc  = (cool_q == COOL_MAX) ? cool_q : cool_q + CW'(1);
  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);
`else
  logic unused_cfg;
  assign unused_cfg = (RETRY_PERIODS != 0);
`endif

  assign blank_inc = (blank_q == BLANK_MAX) ? blank_q : blank_q + BW'(1);
  assign flt_inc   = (flt_q == FLT_MAX) ? flt_q : flt_q + FW'(1);

  // The sync cycle itself is always blanked, whatever the counter says.
  assign qual = (bus.OVR_I_lft | bus.OVR_I_rght) && (blank_q == BLANK_MAX) && !bus.PWM_sync;
  assign shut = bus.PWM_sync && prd_q && (flt_inc == FLT_MAX);

  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    flt_d   = flt_q;
    prd_d   = prd_q;
`ifdef OVR_I_RETRY_EN
    cool_d  = cool_q;
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        blank_d = '0;
        flt_d   = '0;
        prd_d   = 1'b0;
        if (bus.en_req) state_d = ST_RUN;
      end
      ST_RUN: begin
        blank_d = bus.PWM_sync ? '0 : blank_inc;
        if (bus.PWM_sync) begin
          prd_d = 1'b0;
          flt_d = prd_q ? flt_inc : '0;
        end else begin
          prd_d = prd_q | qual;
        end
        // Shutdown outranks a simultaneous drop of en_req.
        if (shut) begin
`ifdef OVR_I_RETRY_EN
          state_d = (retry_q == RETRY_MAX) ? ST_LATCHED : ST_COOL;
          cool_d  = '0;
`else
          state_d = ST_LATCHED;
`endif
        end else if (!bus.en_req) begin
          state_d = ST_IDLE;
`ifdef OVR_I_RETRY_EN
          retry_d = '0;
`endif
        end
      end
`ifdef OVR_I_RETRY_EN
      ST_COOL: begin
        if (!bus.en_req) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else if (bus.PWM_sync) begin
          if (cool_inc == COOL_MAX) begin
            state_d = ST_RUN;
            retry_d = retry_inc;
            blank_d = '0;
            flt_d   = '0;
            prd_d   = 1'b0;
            cool_d  = '0;
          end else begin
            cool_d = cool_inc;
          end
        end
      end
`endif
      ST_LATCHED: begin
        if (bus.clr_fault) begin
          state_d = ST_IDLE;
`ifdef OVR_I_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      blank_q <= '0;
      flt_q   <= '0;
      prd_q   <= 1'b0;
      drv_q   <= 1'b0;
      sht_q   <= 1'b0;
      lat_q   <= 1'b0;
`ifdef OVR_I_RETRY_EN
      cool_q  <= '0;
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      flt_q   <= flt_d;
      prd_q   <= prd_d;
      drv_q   <= (state_d == ST_RUN);
      lat_q   <= (state_d == ST_LATCHED);
`ifdef OVR_I_RETRY_EN
      sht_q   <= (state_d == ST_LATCHED) || (state_d == ST_COOL);
      cool_q  <= cool_d;
      retry_q <= retry_d;
`else
      sht_q   <= (state_d == ST_LATCHED);
`endif
    end
  end

  assign bus.drv_en        = drv_q;
  assign bus.OVR_I_shtdwn  = sht_q;
  assign bus.fault_latched = lat_q;
`ifdef OVR_I_RETRY_EN
  assign bus.retry_cnt     = retry_q;
`else
  assign bus.retry_cnt     = '0;
`endif

endmodule

// File: doc/ovr_i_supervisor.md
# ovr_i_supervisor

Over-current supervisor and enable sequencer for the motor driver. It sits between the top-level drive-enable request and the PWM outputs of the left and right motor channels. It qualifies the raw `OVR_I_lft`/`OVR_I_rght` comparator flags against a blanking window that restarts at every `PWM_sync`, and counts consecutive PWM periods that contain a qualified fault. It then shuts the drive down, runs a cool-down/retry schedule, and latches a hard fault when retries are exhausted.

## Interface
Parameters:
- `BLANK_CYC`, 32: clocks after `PWM_sync` during which over-current flags are ignored.
- `FAULT_LIMIT`, 4: consecutive faulty PWM periods that trigger shutdown (≥1).
- `RETRY_PERIODS`, 8: PWM periods spent in cool-down before a retry (≥1).
- `MAX_RETRY`, 2: automatic retries allowed before the fault latches.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous and active-low. One clock; all state is reset synchronously on `clk` when `rst_n`=0.
- `PWM_sync` in 1: single-cycle pulse at the start of each PWM period.
- `OVR_I_lft` in 1: raw left over-current flag.
- `OVR_I_rght` in 1: raw right over-current flag.
- `en_req` in 1: level request to drive the motors.
- `clr_fault` in 1: single-cycle pulse that clears a latched fault.
- `drv_en` out 1: gates the PWM outputs; 1 only in RUN.
- `OVR_I_shtdwn` out 1: 1 in COOLDOWN and LATCHED.
- `fault_latched` out 1: 1 only in LATCHED.
- `retry_cnt` out `$clog2(MAX_RETRY+1)`: retries consumed since the last clean start.

## Operation
States: IDLE, RUN, COOLDOWN, LATCHED. Reset enters IDLE with all counters at 0 and all outputs at 0.

- **IDLE:**
  - `en_req`=1 → RUN.
  - On entry, `blank_cnt`, `flt_cnt` and the period flag are cleared.
- **RUN:**
  - `blank_cnt` is set to 0 on `PWM_sync` and otherwise increments, saturating at `BLANK_CYC`.
  - A qualified fault is (`OVR_I_lft`|`OVR_I_rght`) while `blank_cnt`==`BLANK_CYC`. The `PWM_sync` cycle is always blanked.
  - Any qualified fault sets `prd_flt` (sticky).
  - On `PWM_sync`: if `prd_flt`=1, `flt_cnt`++; otherwise `flt_cnt`←0. In both cases `prd_flt`←0.
  - When the increment makes `flt_cnt`==`FAULT_LIMIT`, the block shuts down: go to LATCHED if `retry_cnt`==`MAX_RETRY`, else go to COOLDOWN.
  - `en_req`=0 → IDLE, with `retry_cnt`←0.
  - Shutdown has priority over `en_req`=0 in the same cycle.
- **COOLDOWN:**
  - `cool_cnt` counts `PWM_sync` pulses.
  - On the `RETRY_PERIODS`th pulse: `retry_cnt`++ and go to RUN, re-entering with `blank_cnt`=0 and `flt_cnt`=0.
  - `en_req`=0 → IDLE, with `retry_cnt`←0.
- **LATCHED:**
  - Held regardless of `en_req`.
  - `clr_fault` → IDLE, with `retry_cnt`←0.
  - `clr_fault` in any other state is ignored.

Widths and arithmetic:
- `blank_cnt`: `$clog2(BLANK_CYC+1)` bits.
- `flt_cnt`: `$clog2(FAULT_LIMIT+1)` bits.
- `cool_cnt`: `$clog2(RETRY_PERIODS+1)` bits.
- All counters are unsigned and saturating, with no wrap-around.

## Timing
- All outputs are registered.
- `drv_en` rises the cycle after `en_req` is sampled high in IDLE.
- Shutdown: at the `PWM_sync` edge that completes the `FAULT_LIMIT`th faulty period, the state changes. On the next cycle `drv_en`=0 and `OVR_I_shtdwn`=1.
- The first partial period after entering RUN counts as a full period at the next `PWM_sync`.
- Retry: `drv_en` returns 1 the cycle after the `RETRY_PERIODS`th `PWM_sync` in COOLDOWN.
- `clr_fault` in LATCHED: `OVR_I_shtdwn` and `fault_latched` go to 0 the next cycle. `drv_en` stays 0 until `en_req` is sampled in IDLE, at least 1 further cycle.
- `rst_n`=0 at any point, including mid-COOLDOWN or LATCHED: the next edge gives IDLE with all outputs 0.

## Configuration
- `OVR_I_RETRY_EN` defined: COOLDOWN and the retry schedule are compiled in, as described above.
- `OVR_I_RETRY_EN` not defined:
  - COOLDOWN and `cool_cnt` are removed.
  - Every shutdown goes directly to LATCHED.
  - `retry_cnt` is tied to 0.

## Test plan
All scenarios use the default parameters with `OVR_I_RETRY_EN` defined, and a `PWM_sync` period of 1024 clocks.

1. **Blanking:** `en_req`=1; `OVR_I_lft` pulses high only on clocks 1–31 after each `PWM_sync` for 40 periods → `OVR_I_shtdwn` stays 0, `drv_en` stays 1, `flt_cnt` stays 0.
2. **Qualified shutdown:** `OVR_I_rght` held high continuously → `OVR_I_shtdwn`=1 and `drv_en`=0 exactly 1 clock after the 4th `PWM_sync` following entry to RUN.
3. **Consecutiveness:** faults in periods 1, 2 and 3, period 4 clean, then faults again → no shutdown until the 4th consecutive faulty period after the clean one.
4. **Retry and latch:** `OVR_I_lft` held high continuously:
   - Two retries occur; after each, `drv_en` returns 1 after 8 `PWM_sync` pulses, with `retry_cnt` = 1, then 2.
   - The third shutdown sets `fault_latched`=1 and holds it.
   - `clr_fault` then gives IDLE and `retry_cnt`=0.
5. **Priority and reset:**
   - `en_req` falls on the same cycle as the shutdown-triggering `PWM_sync` → COOLDOWN is entered (fault wins).
   - `rst_n`=0 asserted in LATCHED → all outputs are 0 after one clock.
6. **Macro off:** rebuild without `OVR_I_RETRY_EN`; apply scenario 2 stimulus → `fault_latched`=1 after the first shutdown and no retry occurs.
